// File: rtl/fifo_frame_writer.sv
// Producer-side test-pattern engine for the async FIFO write port (wr_clk domain).
// Emits one IMG_W x IMG_H frame per accepted start, honouring fifo_full back-pressure.
module fifo_frame_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int COL_BITS   = 5,
    parameter int ROW_BITS   = 5
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  start,
    input  logic [1:0]            pattern_sel,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(IMG_W - 1);
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(IMG_H - 1);

    state_t                       state;
    state_t                       state_nxt;
    logic [COL_BITS-1:0]          col;
    logic [ROW_BITS-1:0]          row;
    logic [COL_BITS+ROW_BITS-1:0] pix_idx;
    logic [1:0]                   sel_q;
    logic [DATA_WIDTH-1:0]        seed_q;
    logic [DATA_WIDTH-1:0]        pattern_pix;
    logic                         start_ok;
    logic                         accept;
    logic                         last_col;
    logic                         last_pix;

    assign start_ok = (state == IDLE) && start;
    assign accept   = (state == RUN) && !fifo_full;
    assign last_col = (col == COL_MAX);
    assign last_pix = last_col && (row == ROW_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first keeps this combinational and latch-free.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && last_pix) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_wr_en   = accept;
        busy         = (state != IDLE);
        frame_done   = (state == DONE);
        fifo_wr_data = (state == RUN) ? pattern_pix : '0;
    end

    // Pixel value depends only on registered state, so it holds across stalls.
    always_comb begin
        pattern_pix = seed_q;
        case (sel_q)
            2'd0:    pattern_pix = seed_q + DATA_WIDTH'(pix_idx);
            2'd1:    pattern_pix = DATA_WIDTH'(col) ^ DATA_WIDTH'(row);
            2'd2:    pattern_pix = seed_q;
            default: pattern_pix = (col[0] ^ row[0]) ? ~seed_q : seed_q;
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            col     <= '0;
            row     <= '0;
            pix_idx <= '0;
            sel_q   <= '0;
            seed_q  <= '0;
        end else if (start_ok) begin
            col     <= '0;
            row     <= '0;
            pix_idx <= '0;
            sel_q   <= pattern_sel;
            seed_q  <= seed;
        end else if (accept) begin
            pix_idx <= pix_idx + 1'b1;
            if (last_col) begin
                col <= '0;
                row <= last_pix ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            stall_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            if (start_ok) begin
                stall_cnt <= '0;
            end else if ((state == RUN) && fifo_full && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (state == DONE) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Directed self-checking bench for fifo_frame_writer: patterns, back-pressure,
// ignored starts, mid-frame reset and stall-counter saturation.
module tb_fifo_frame_writer;

    logic        wr_clk;
    logic        wr_rst_n;
    logic        start;
    logic [1:0]  pattern_sel;
    logic [7:0]  seed;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        busy;
    logic        frame_done;
    logic [15:0] stall_cnt;
    logic [15:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] cap [0:1023];

    fifo_frame_writer #(
        .DATA_WIDTH(8), .IMG_W(32), .IMG_H(32), .COL_BITS(5), .ROW_BITS(5)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rst_n     (wr_rst_n),
        .start        (start),
        .pattern_sel  (pattern_sel),
        .seed         (seed),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy),
        .frame_done   (frame_done),
        .stall_cnt    (stall_cnt),
        .frame_cnt    (frame_cnt)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic start_frame(input logic [1:0] sel, input logic [7:0] sd);
        pattern_sel = sel;
        seed        = sd;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Collects strobed pixels until frame_done or a cycle budget expires.
    // Optionally stalls for stall_len cycles once stall_at pixels are accepted,
    // and optionally pokes start mid-frame with a different configuration.
    task automatic capture(input int stall_at, input int stall_len, input bit poke,
                           output int n, output int c, output int hold_err);
        int stalled;
        n = 0; c = 0; hold_err = 0; stalled = 0;
        while (c < 1200) begin
            if (poke && c == 10) begin
                start = 1'b1; seed = 8'h55; pattern_sel = 2'd2;
            end else begin
                start = 1'b0;
            end
            fifo_full = (n == stall_at && stalled < stall_len);
            if (fifo_full) stalled++;
            #1;
            if (frame_done) break;
            if (fifo_full) begin
                if (fifo_wr_en || fifo_wr_data !== 8'(stall_at)) hold_err++;
            end else if (fifo_wr_en) begin
                if (n < 1024) cap[n] = fifo_wr_data;
                n++;
            end
            tick();
            c++;
        end
        start = 1'b0;
        fifo_full = 1'b0;
    endtask

    initial begin
        int n, c, he, bad;

        wr_rst_n = 1'b0; start = 1'b0; pattern_sel = 2'd0; seed = 8'h00; fifo_full = 1'b0;
        #12;
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_wr_data", fifo_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_frames", frame_cnt, 0);
        wr_rst_n = 1'b1;
        tick();

        // T1: ramp from 0x10, unstalled
        start_frame(2'd0, 8'h10);
        check("t1_first_strobe", fifo_wr_en, 1);
        capture(-1, 0, 1'b0, n, c, he);
        check("t1_count", n, 1024);
        check("t1_cycles", c, 1024);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (cap[i] !== 8'(8'h10 + i)) bad++;
        check("t1_data_errs", bad, 0);
        check("t1_last", cap[1023], 8'h0F);
        check("t1_done", frame_done, 1);
        check("t1_done_busy", busy, 1);
        check("t1_done_wr_en", fifo_wr_en, 0);
        check("t1_done_data", fifo_wr_data, 0);
        tick();
        check("t1_done_pulse", frame_done, 0);
        check("t1_idle", busy, 0);
        check("t1_frames", frame_cnt, 1);
        check("t1_stall", stall_cnt, 0);

        // T3: ramp from 0, 7-cycle stall after pixel 100
        start_frame(2'd0, 8'h00);
        capture(101, 7, 1'b0, n, c, he);
        check("t3_count", n, 1024);
        check("t3_cycles", c, 1031);
        check("t3_hold_errs", he, 0);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (cap[i] !== 8'(i)) bad++;
        check("t3_data_errs", bad, 0);
        check("t3_stall", stall_cnt, 7);
        tick();
        check("t3_frames", frame_cnt, 2);

        // T4: start ignored in RUN and DONE, then back-to-back xor frame
        start_frame(2'd0, 8'h00);
        capture(-1, 0, 1'b1, n, c, he);
        check("t4_count", n, 1024);
        check("t4_cycles", c, 1024);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (cap[i] !== 8'(i)) bad++;
        check("t4_data_errs", bad, 0);
        check("t4_done", frame_done, 1);
        pattern_sel = 2'd2; seed = 8'h77; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_done_start_ignored", busy, 0);
        check("t4_frames", frame_cnt, 3);
        start_frame(2'd1, 8'h00);
        capture(-1, 0, 1'b0, n, c, he);
        check("t2_count", n, 1024);
        check("t2_cycles", c, 1024);
        check("t2_px_3_5", cap[5*32+3], 8'h06);
        check("t2_px_1_1", cap[33], 8'h00);
        check("t2_px_31_0", cap[31], 8'h1F);
        check("t2_px_31_31", cap[1023], 8'h00);
        tick();
        check("t4_frames_b2b", frame_cnt, 4);

        // T5: reset at pixel 500, then restart from pixel 0
        start_frame(2'd0, 8'h00);
        repeat (500) tick();
        check("t5_px500", fifo_wr_data, 8'hF4);
        wr_rst_n = 1'b0;
        #1;
        check("t5_rst_wr_en", fifo_wr_en, 0);
        check("t5_rst_busy", busy, 0);
        tick();
        check("t5_rst_done", frame_done, 0);
        check("t5_rst_stall", stall_cnt, 0);
        check("t5_rst_frames", frame_cnt, 0);
        check("t5_rst_data", fifo_wr_data, 0);
        wr_rst_n = 1'b1;
        tick();
        start_frame(2'd0, 8'h20);
        capture(-1, 0, 1'b0, n, c, he);
        check("t5_count", n, 1024);
        check("t5_first", cap[0], 8'h20);
        check("t5_px500_new", cap[500], 8'h14);
        tick();
        check("t5_frames", frame_cnt, 1);

        // T6: checker and flat patterns, then stuck-full saturation
        start_frame(2'd3, 8'hA5);
        capture(-1, 0, 1'b0, n, c, he);
        check("t6_chk_0_0", cap[0], 8'hA5);
        check("t6_chk_1_0", cap[1], 8'h5A);
        check("t6_chk_0_1", cap[32], 8'h5A);
        check("t6_chk_1_1", cap[33], 8'hA5);
        tick();
        start_frame(2'd2, 8'hA5);
        capture(-1, 0, 1'b0, n, c, he);
        check("t6_flat_count", n, 1024);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (cap[i] !== 8'hA5) bad++;
        check("t6_flat_errs", bad, 0);
        tick();
        check("t6_frames", frame_cnt, 3);

        fifo_full = 1'b1;
        start_frame(2'd2, 8'hA5);
        check("t6_full_wr_en", fifo_wr_en, 0);
        repeat (65534) tick();
        check("t6_stall_fffe", stall_cnt, 16'hFFFE);
        repeat (70000 - 65534) tick();
        check("t6_stall_sat", stall_cnt, 16'hFFFF);
        check("t6_still_busy", busy, 1);
        check("t6_no_done", frame_done, 0);
        wr_rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_stall", stall_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
